// File: rtl/fs_full_subtractor.sv
// Registered ripple-borrow full subtractor: d = a - b - c, br = borrow-out.
// One-cycle latency, one result per cycle, outputs hold while in_valid is low.
module fs_full_subtractor #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c,
    output logic [WIDTH-1:0] d,
    output logic             br,
    output logic             out_valid
);

    logic [WIDTH:0]   bin;
    logic [WIDTH-1:0] diff;

    assign bin[0] = c;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign diff[i]  = a[i] ^ b[i] ^ bin[i];
        assign bin[i+1] = (~a[i] & b[i])
                        | (~a[i] & bin[i])
                        | (b[i] & bin[i]);
    end

    // Result registers load only on valid input so idle inputs never leak through.
    always_ff @(posedge clk) begin
        if (rst) begin
            d  <= '0;
            br <= 1'b0;
        end else if (in_valid) begin
            d  <= diff;
            br <= bin[WIDTH];
        end
    end

    // Valid flag tracks in_valid every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
        end
    end

endmodule

// File: tb/tb_fs_full_subtractor.sv
// Directed and random checks for fs_full_subtractor at WIDTH 1, 8 and 16.
// Table vectors for the truth table and wrap/boundary cases, model for random.
module tb_fs_full_subtractor;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    logic       v1, v8, v16;
    logic       a1, b1, c1, c8, c16;
    logic [7:0] a8, b8;
    logic [15:0] a16, b16;
    logic       d1, br1, ov1;
    logic [7:0] d8;
    logic       br8, ov8;
    logic [15:0] d16;
    logic       br16, ov16;

    fs_full_subtractor #(.WIDTH(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(v1),
        .a(a1), .b(b1), .c(c1),
        .d(d1), .br(br1), .out_valid(ov1)
    );

    fs_full_subtractor #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(v8),
        .a(a8), .b(b8), .c(c8),
        .d(d8), .br(br8), .out_valid(ov8)
    );

    fs_full_subtractor #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst(rst), .in_valid(v16),
        .a(a16), .b(b16), .c(c16),
        .d(d16), .br(br16), .out_valid(ov16)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       c;
        logic [7:0] d;
        logic       br;
    } vec_t;

    vec_t t1 [8];
    vec_t t8 [4];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tot_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    logic [16:0] gold;
    logic [15:0] m_d;
    logic        m_br;
    logic        m_v;
    logic [15:0] nd;
    logic        nbr;
    logic        nv;

    initial begin
        t1[0] = '{a:8'd0, b:8'd0, c:1'b0, d:8'd0, br:1'b0};
        t1[1] = '{a:8'd0, b:8'd0, c:1'b1, d:8'd1, br:1'b1};
        t1[2] = '{a:8'd0, b:8'd1, c:1'b0, d:8'd1, br:1'b1};
        t1[3] = '{a:8'd0, b:8'd1, c:1'b1, d:8'd0, br:1'b1};
        t1[4] = '{a:8'd1, b:8'd0, c:1'b0, d:8'd1, br:1'b0};
        t1[5] = '{a:8'd1, b:8'd0, c:1'b1, d:8'd0, br:1'b0};
        t1[6] = '{a:8'd1, b:8'd1, c:1'b0, d:8'd0, br:1'b0};
        t1[7] = '{a:8'd1, b:8'd1, c:1'b1, d:8'd1, br:1'b1};
        t8[0] = '{a:8'h00, b:8'h01, c:1'b1, d:8'hFE, br:1'b1};
        t8[1] = '{a:8'hFF, b:8'hFF, c:1'b0, d:8'h00, br:1'b0};
        t8[2] = '{a:8'h10, b:8'h0F, c:1'b1, d:8'h00, br:1'b0};
        t8[3] = '{a:8'h10, b:8'h10, c:1'b1, d:8'hFF, br:1'b1};

        v1 = 1'b1; a1 = 1'b1; b1 = 1'b0; c1 = 1'b0;
        v8 = 1'b1; a8 = 8'h01; b8 = 8'h00; c8 = 1'b0;
        v16 = 1'b0; a16 = '0; b16 = '0; c16 = 1'b0;

        // reset with valid operands present
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_d1", {63'd0, d1}, 64'd0);
            chk("rst_br1", {63'd0, br1}, 64'd0);
            chk("rst_ov1", {63'd0, ov1}, 64'd0);
            chk("rst_d8", {56'd0, d8}, 64'd0);
            chk("rst_ov8", {63'd0, ov8}, 64'd0);
        end
        rst = 1'b0;
        v1 = 1'b0;
        v8 = 1'b0;
        tick();
        chk("post_rst_ov1", {63'd0, ov1}, 64'd0);
        chk("post_rst_d1", {63'd0, d1}, 64'd0);

        // exhaustive single-bit, back to back
        v1 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            a1 = t1[i].a[0];
            b1 = t1[i].b[0];
            c1 = t1[i].c;
            tick();
            chk($sformatf("w1_d[%0d]", i), {63'd0, d1}, {56'd0, t1[i].d});
            chk($sformatf("w1_br[%0d]", i), {63'd0, br1}, {63'd0, t1[i].br});
            chk($sformatf("w1_ov[%0d]", i), {63'd0, ov1}, 64'd1);
        end

        // hold: load 010, then idle with 111 on the inputs
        a1 = 1'b0; b1 = 1'b1; c1 = 1'b0;
        tick();
        chk("hold_load_d", {63'd0, d1}, 64'd1);
        chk("hold_load_br", {63'd0, br1}, 64'd1);
        v1 = 1'b0;
        a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_d", {63'd0, d1}, 64'd1);
            chk("hold_br", {63'd0, br1}, 64'd1);
            chk("hold_ov", {63'd0, ov1}, 64'd0);
        end

        // 8-bit wrap and borrow boundary
        v8 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a8 = t8[i].a;
            b8 = t8[i].b;
            c8 = t8[i].c;
            tick();
            chk($sformatf("w8_d[%0d]", i), {56'd0, d8}, {56'd0, t8[i].d});
            chk($sformatf("w8_br[%0d]", i), {63'd0, br8}, {63'd0, t8[i].br});
            chk($sformatf("w8_ov[%0d]", i), {63'd0, ov8}, 64'd1);
        end
        v8 = 1'b0;

        // mid-stream reset discards the operand presented with it
        a8 = 8'h05; b8 = 8'h02; c8 = 1'b0; v8 = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        v8 = 1'b0;
        chk("midrst_d8", {56'd0, d8}, 64'd0);
        chk("midrst_ov8", {63'd0, ov8}, 64'd0);
        tick();
        chk("midrst_hold_d8", {56'd0, d8}, 64'd0);

        // random 16-bit with occasional reset
        m_d = '0; m_br = 1'b0; m_v = 1'b0;
        for (int i = 0; i < 10000; i++) begin
            a16 = 16'($urandom);
            b16 = 16'($urandom);
            c16 = 1'($urandom);
            v16 = 1'($urandom);
            rst = ($urandom_range(0, 99) == 0);
            gold = {1'b0, a16} - {1'b0, b16} - {16'd0, c16};
            nd = m_d;
            nbr = m_br;
            nv = v16;
            if (rst) begin
                nd = '0;
                nbr = 1'b0;
                nv = 1'b0;
            end else if (v16) begin
                nd = gold[15:0];
                nbr = gold[16];
            end
            tick();
            m_d = nd;
            m_br = nbr;
            m_v = nv;
            chk($sformatf("rnd[%0d]", i), {46'd0, ov16, br16, d16},
                {46'd0, m_v, m_br, m_d});
        end
        rst = 1'b0;
        v16 = 1'b0;

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
